// File: rtl/native_pkg.sv
// Shared types and elaboration helpers for the native_dot_acc streaming dot-product engine.
// The lane-slice macro picks lane idx of width w out of a flat packed vector.
`ifndef NATIVE_PKG_SV
`define NATIVE_PKG_SV

`define NATIVE_LANE(vec, idx, w) vec[(idx)*(w) +: (w)]

package native_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 32'sd0;
        for (int v = 32'sd1; v < n; v = v * 32'sd2) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

    // One extension bit per operand keeps unsigned products positive in a signed word.
    function automatic int prod_width(input int ww, input int aw);
        return ww + aw + 32'sd2;
    endfunction

    function automatic int tree_width(input int in_w, input int n);
        return in_w + clog2(n);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] c);
        if (c == 16'hFFFF) begin
            return c;
        end else begin
            return c + 16'd1;
        end
    endfunction

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
        logic sgn;
    } sb_t;

endpackage

`endif

// File: rtl/native_add_tree.sv
// Pipelined signed reduction tree: N inputs of IN_W bits collapse to one sum, one
// register level per halving, each level one bit wider; a sideband word rides along.
module native_add_tree
    import native_pkg::*;
#(
    parameter int N    = 128,
    parameter int IN_W = 10,
    parameter int SB_W = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic [SB_W-1:0]                in_sb,
    input  logic [N*IN_W-1:0]              in_data,
    output logic [SB_W-1:0]                out_sb,
    output logic [tree_width(IN_W, N)-1:0] out_sum
);

    localparam int LOG2N = clog2(N);

    for (genvar l = 1; l <= LOG2N; l++) begin : g_lvl
        localparam int CNT = N >> l;
        localparam int W   = IN_W + l;

        logic [2*CNT*(W-1)-1:0] src_s;
        logic [SB_W-1:0]        src_sb_s;
        logic [CNT*W-1:0]       sum_d;
        logic [CNT*W-1:0]       sum_q;
        logic [SB_W-1:0]        sb_d;
        logic [SB_W-1:0]        sb_q;

        if (l == 1) begin : g_src_in
            assign src_s    = in_data;
            assign src_sb_s = in_sb;
        end else begin : g_src_lvl
            assign src_s    = g_lvl[l-1].sum_q;
            assign src_sb_s = g_lvl[l-1].sb_q;
        end

        // pairwise sign-extending add of adjacent nodes from the level below
        always_comb begin
            sum_d = sum_q;
            sb_d  = sb_q;
            if (en) begin
                sb_d = src_sb_s;
                for (int k = 0; k < CNT; k++) begin
                    sum_d[k*W +: W] = {src_s[(2*k+1)*(W-1)-1], src_s[(2*k)*(W-1) +: (W-1)]}
                                    + {src_s[(2*k+2)*(W-1)-1], src_s[(2*k+1)*(W-1) +: (W-1)]};
                end
            end else begin
                sum_d = sum_q;
                sb_d  = sb_q;
            end
        end

        // level register
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q <= '0;
                sb_q  <= '0;
            end else begin
                sum_q <= sum_d;
                sb_q  <= sb_d;
            end
        end
    end

    assign out_sum = g_lvl[LOG2N].sum_q;
    assign out_sb  = g_lvl[LOG2N].sb_q;

endmodule

// File: rtl/native_dot_acc.sv
// Streaming signed/unsigned dot-product lane: input register, multipliers, pipelined
// adder tree, multi-beat accumulator with output saturation and valid/ready handshake.
module native_dot_acc
    import native_pkg::*;
#(
    parameter int N            = 128,
    parameter int WEIGHT_WIDTH = 4,
    parameter int ACT_WIDTH    = 4,
    parameter int ACC_WIDTH    = 32,
    parameter int OUT_WIDTH    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_first,
    input  logic                        in_last,
    input  logic                        in_signed,
    input  logic [N*WEIGHT_WIDTH-1:0]   i_weights_flat,
    input  logic [N*ACT_WIDTH-1:0]      i_acts_flat,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_WIDTH-1:0]        result,
    output logic                        sat,
    output logic [15:0]                 beats
);

    localparam int LOG2N = clog2(N);
    localparam int PW    = prod_width(WEIGHT_WIDTH, ACT_WIDTH);
    localparam int TW    = PW + LOG2N;
    localparam int SB_W  = $bits(sb_t);

    localparam logic [ACC_WIDTH-1:0] ACC_SMAX = ACC_WIDTH'((64'd1 << (OUT_WIDTH - 1)) - 64'd1);
    localparam logic [ACC_WIDTH-1:0] ACC_SMIN = ~ACC_SMAX;
    localparam logic [ACC_WIDTH-1:0] ACC_UMAX = ACC_WIDTH'((64'd1 << OUT_WIDTH) - 64'd1);
    localparam logic [OUT_WIDTH-1:0] RES_SMAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] RES_SMIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [OUT_WIDTH-1:0] RES_UMAX = {OUT_WIDTH{1'b1}};

    function automatic logic [PW-1:0] lane_mul(input logic [WEIGHT_WIDTH-1:0] w,
                                               input logic [ACT_WIDTH-1:0]    a,
                                               input logic                    sgn);
        logic [PW-1:0] we;
        logic [PW-1:0] ae;
        we = {{(PW-WEIGHT_WIDTH){sgn & w[WEIGHT_WIDTH-1]}}, w};
        ae = {{(PW-ACT_WIDTH){sgn & a[ACT_WIDTH-1]}}, a};
        return we * ae;
    endfunction

    logic                      en_s;
    sb_t                       s0_sb_d, s0_sb_q;
    logic [N*WEIGHT_WIDTH-1:0] s0_w_d, s0_w_q;
    logic [N*ACT_WIDTH-1:0]    s0_a_d, s0_a_q;
    sb_t                       s1_sb_d, s1_sb_q;
    logic [N*PW-1:0]           s1_prod_d, s1_prod_q;
    sb_t                       tree_sb_s;
    logic [TW-1:0]             tree_sum_s;
    logic [ACC_WIDTH-1:0]      tree_ext_s, base_s, sum_s;
    logic [OUT_WIDTH-1:0]      clamp_s;
    logic                      clamp_sat_s;
    logic [15:0]               cnt_next_s;
    logic [ACC_WIDTH-1:0]      acc_d, acc_q;
    logic [15:0]               cnt_d, cnt_q;
    logic [OUT_WIDTH-1:0]      result_d, result_q;
    logic                      sat_d, sat_q;
    logic [15:0]               beats_d, beats_q;
    logic                      out_valid_d, out_valid_q;

    // The whole pipeline freezes only while a finished result is waiting to be taken.
    assign en_s      = ~(out_valid_q & ~out_ready);
    assign in_ready  = en_s;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign sat       = sat_q;
    assign beats     = beats_q;

    // input stage capture
    always_comb begin
        s0_sb_d = s0_sb_q;
        s0_w_d  = s0_w_q;
        s0_a_d  = s0_a_q;
        if (en_s) begin
            s0_sb_d = sb_t'{valid: in_valid, first: in_first, last: in_last, sgn: in_signed};
            s0_w_d  = i_weights_flat;
            s0_a_d  = i_acts_flat;
        end else begin
            s0_sb_d = s0_sb_q;
            s0_w_d  = s0_w_q;
            s0_a_d  = s0_a_q;
        end
    end

    // per-lane multiply with per-beat operand extension
    always_comb begin
        s1_sb_d   = s1_sb_q;
        s1_prod_d = s1_prod_q;
        if (en_s) begin
            s1_sb_d = s0_sb_q;
            for (int i = 0; i < N; i++) begin
                `NATIVE_LANE(s1_prod_d, i, PW) = lane_mul(`NATIVE_LANE(s0_w_q, i, WEIGHT_WIDTH),
                                                          `NATIVE_LANE(s0_a_q, i, ACT_WIDTH),
                                                          s0_sb_q.sgn);
            end
        end else begin
            s1_sb_d   = s1_sb_q;
            s1_prod_d = s1_prod_q;
        end
    end

    // input and multiply stage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_sb_q   <= '0;
            s0_w_q    <= '0;
            s0_a_q    <= '0;
            s1_sb_q   <= '0;
            s1_prod_q <= '0;
        end else begin
            s0_sb_q   <= s0_sb_d;
            s0_w_q    <= s0_w_d;
            s0_a_q    <= s0_a_d;
            s1_sb_q   <= s1_sb_d;
            s1_prod_q <= s1_prod_d;
        end
    end

    native_add_tree #(
        .N    (N),
        .IN_W (PW),
        .SB_W (SB_W)
    ) u_tree (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en_s),
        .in_sb   (s1_sb_q),
        .in_data (s1_prod_q),
        .out_sb  (tree_sb_s),
        .out_sum (tree_sum_s)
    );

    // group sum and clamp; the last beat's mode selects the clamp range
    always_comb begin
        tree_ext_s  = ACC_WIDTH'($signed(tree_sum_s));
        base_s      = acc_q;
        clamp_s     = '0;
        clamp_sat_s = 1'b0;
        if (tree_sb_s.first) begin
            base_s = '0;
        end else begin
            base_s = acc_q;
        end
        sum_s = base_s + tree_ext_s;
        if (tree_sb_s.sgn) begin
            if ($signed(sum_s) > $signed(ACC_SMAX)) begin
                clamp_s     = RES_SMAX;
                clamp_sat_s = 1'b1;
            end else if ($signed(sum_s) < $signed(ACC_SMIN)) begin
                clamp_s     = RES_SMIN;
                clamp_sat_s = 1'b1;
            end else begin
                clamp_s     = sum_s[OUT_WIDTH-1:0];
                clamp_sat_s = 1'b0;
            end
        end else begin
            if (sum_s > ACC_UMAX) begin
                clamp_s     = RES_UMAX;
                clamp_sat_s = 1'b1;
            end else begin
                clamp_s     = sum_s[OUT_WIDTH-1:0];
                clamp_sat_s = 1'b0;
            end
        end
    end

    // accumulator, beat counter and output handshake
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        sat_d       = sat_q;
        beats_d     = beats_q;
        out_valid_d = out_valid_q;
        cnt_next_s  = sat_inc16(cnt_q);
        if (tree_sb_s.first) begin
            cnt_next_s = 16'd1;
        end else begin
            cnt_next_s = sat_inc16(cnt_q);
        end
        if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (en_s && tree_sb_s.valid) begin
            if (tree_sb_s.last) begin
                result_d    = clamp_s;
                sat_d       = clamp_sat_s;
                beats_d     = cnt_next_s;
                acc_d       = '0;
                cnt_d       = 16'd0;
                out_valid_d = 1'b1;
            end else begin
                acc_d = sum_s;
                cnt_d = cnt_next_s;
            end
        end else begin
            acc_d = acc_q;
            cnt_d = cnt_q;
        end
    end

    // accumulate stage and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            cnt_q       <= 16'd0;
            result_q    <= '0;
            sat_q       <= 1'b0;
            beats_q     <= 16'd0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            sat_q       <= sat_d;
            beats_q     <= beats_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_native_dot_acc.sv
// Self-checking bench for native_dot_acc: single-beat vector table, hand-written
// multi-beat/backpressure/reset sequences, scoreboard compared at the output handshake.
module tb_native_dot_acc;

    localparam int N   = 128;
    localparam int WW  = 4;
    localparam int AW  = 4;
    localparam int OW  = 16;
    localparam int LAT = 10;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, in_ready, in_first, in_last, in_signed;
    logic [N*WW-1:0] w_flat;
    logic [N*AW-1:0] a_flat;
    logic            out_valid, out_ready, sat;
    logic [OW-1:0]   result;
    logic [15:0]     beats;

    native_dot_acc u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_first       (in_first),
        .in_last        (in_last),
        .in_signed      (in_signed),
        .i_weights_flat (w_flat),
        .i_acts_flat    (a_flat),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .result         (result),
        .sat            (sat),
        .beats          (beats)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] res;
        logic        sat;
        logic [15:0] beats;
    } exp_t;

    typedef struct {
        logic [3:0]  w;
        logic [3:0]  a;
        bit          sgn;
        logic [15:0] res;
        logic        sat;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   acc_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint lane_val(input logic [3:0] v, input bit s);
        if (s) return longint'($signed(v));
        return longint'(v);
    endfunction

    function automatic longint dot(input logic [N*WW-1:0] w, input logic [N*AW-1:0] a, input bit s);
        longint t = 0;
        for (int i = 0; i < N; i++) t += lane_val(w[i*WW +: WW], s) * lane_val(a[i*AW +: AW], s);
        return t;
    endfunction

    function automatic exp_t mk_exp(input longint v, input bit s, input int nb);
        exp_t e;
        e.beats = 16'(nb);
        e.sat   = 1'b0;
        e.res   = v[15:0];
        if (s && v > 32767) begin e.res = 16'h7FFF; e.sat = 1'b1; end
        if (s && v < -32768) begin e.res = 16'h8000; e.sat = 1'b1; end
        if (!s && v > 65535) begin e.res = 16'hFFFF; e.sat = 1'b1; end
        return e;
    endfunction

    function automatic logic [N*WW-1:0] fill(input logic [3:0] v);
        logic [N*WW-1:0] r;
        for (int i = 0; i < N; i++) r[i*WW +: WW] = v;
        return r;
    endfunction

    // Enter at a negedge; present the beat, wait for in_ready, return at the negedge after acceptance.
    task automatic beat(input logic [N*WW-1:0] w, input logic [N*AW-1:0] a,
                        input bit s, input bit f, input bit l);
        int k;
        w_flat = w; a_flat = a; in_signed = s; in_first = f; in_last = l; in_valid = 1'b1;
        for (k = 0; k < 200; k++) begin
            if (in_ready) break;
            @(negedge clk);
        end
        if (k == 200) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    endtask

    task automatic group_rand(input int nb, input bit s);
        longint tot = 0;
        logic [N*WW-1:0] w;
        logic [N*AW-1:0] a;
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < N; i++) begin
                w[i*WW +: WW] = 4'($urandom);
                a[i*AW +: AW] = 4'($urandom);
            end
            tot += dot(w, a, s);
            if (b == nb - 1) sb_q.push_back(mk_exp(tot, s, nb));
            beat(w, a, s, b == 0, b == nb - 1);
        end
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 300 && (sb_q.size() != 0 || out_valid); k++) @(negedge clk);
        check("drain_pending", 32'(sb_q.size()), 32'd0);
    endtask

    // scoreboard: every completed output handshake is compared against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", 32'(out_valid), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("result", 32'(result), 32'(mon_e.res));
                check("sat", 32'(sat), 32'(mon_e.sat));
                check("beats", 32'(beats), 32'(mon_e.beats));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl[8];

    initial begin
        int k;
        tbl[0] = '{4'd1,  4'd1,  1'b1, 16'd128,   1'b0};
        tbl[1] = '{4'h8,  4'h8,  1'b1, 16'd8192,  1'b0};
        tbl[2] = '{4'hF,  4'hF,  1'b0, 16'd28800, 1'b0};
        tbl[3] = '{4'hF,  4'hF,  1'b1, 16'd128,   1'b0};
        tbl[4] = '{4'd7,  4'h8,  1'b1, 16'hE400,  1'b0};
        tbl[5] = '{4'd0,  4'd9,  1'b0, 16'd0,     1'b0};
        tbl[6] = '{4'hF,  4'h8,  1'b0, 16'd15360, 1'b0};
        tbl[7] = '{4'hF,  4'd7,  1'b1, 16'hFC80,  1'b0};

        rst_n = 1'b0; out_ready = 1'b1; w_flat = '0; a_flat = '0; in_signed = 1'b0;
        idle();
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // single signed beat with latency measurement on an empty pipeline
        sb_q.push_back(exp_t'{16'd128, 1'b0, 16'd1});
        beat(fill(4'd1), fill(4'd1), 1'b1, 1'b1, 1'b1);
        idle();
        for (k = 0; k < 50 && !out_valid; k++) @(negedge clk);
        check("latency", 32'(cyc - acc_cyc + 1), 32'(LAT));

        // table of single-beat vectors, issued back to back
        for (int i = 0; i < 8; i++) begin
            sb_q.push_back(exp_t'{tbl[i].res, tbl[i].sat, 16'd1});
            beat(fill(tbl[i].w), fill(tbl[i].a), tbl[i].sgn, 1'b1, 1'b1);
        end
        idle();

        // positive saturation over six beats
        sb_q.push_back(exp_t'{16'h7FFF, 1'b1, 16'd6});
        for (int b = 0; b < 6; b++) beat(fill(4'd7), fill(4'd7), 1'b1, b == 0, b == 5);
        // negative saturation over five beats
        sb_q.push_back(exp_t'{16'h8000, 1'b1, 16'd5});
        for (int b = 0; b < 5; b++) beat(fill(4'h8), fill(4'd7), 1'b1, b == 0, b == 4);
        // unsigned saturation over three beats
        sb_q.push_back(exp_t'{16'hFFFF, 1'b1, 16'd3});
        for (int b = 0; b < 3; b++) beat(fill(4'hF), fill(4'hF), 1'b0, b == 0, b == 2);
        // first mid-group discards the partial sum
        sb_q.push_back(exp_t'{16'd256, 1'b0, 16'd2});
        beat(fill(4'd7), fill(4'd7), 1'b1, 1'b1, 1'b0);
        beat(fill(4'd1), fill(4'd1), 1'b1, 1'b1, 1'b0);
        beat(fill(4'd1), fill(4'd1), 1'b1, 1'b0, 1'b1);
        // beat after last without first starts from zero
        sb_q.push_back(exp_t'{16'd128, 1'b0, 16'd1});
        beat(fill(4'd1), fill(4'd1), 1'b1, 1'b1, 1'b1);
        sb_q.push_back(exp_t'{16'd128, 1'b0, 16'd1});
        beat(fill(4'd1), fill(4'd1), 1'b1, 1'b0, 1'b1);
        // random lanes, mixed group lengths and modes
        for (int g = 0; g < 6; g++) group_rand(1 + (g % 3), 1'($urandom));
        idle();
        drain();

        // backpressure: three groups queued while the consumer stalls
        out_ready = 1'b0;
        sb_q.push_back(exp_t'{16'd128, 1'b0, 16'd1});
        beat(fill(4'd1), fill(4'd1), 1'b1, 1'b1, 1'b1);
        sb_q.push_back(exp_t'{16'd256, 1'b0, 16'd1});
        beat(fill(4'd2), fill(4'd1), 1'b1, 1'b1, 1'b1);
        sb_q.push_back(exp_t'{16'd384, 1'b0, 16'd1});
        beat(fill(4'd3), fill(4'd1), 1'b1, 1'b1, 1'b1);
        idle();
        for (k = 0; k < 50 && !out_valid; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_result_held", 32'(result), 32'd128);
        out_ready = 1'b1;
        drain();

        // reset during beat two of a four-beat group
        beat(fill(4'd1), fill(4'd1), 1'b1, 1'b1, 1'b0);
        w_flat = fill(4'd1); a_flat = fill(4'd1); in_first = 1'b0; in_last = 1'b0; in_valid = 1'b1;
        #2 rst_n = 1'b0;
        idle();
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_sat", 32'(sat), 32'd0);
        check("mid_rst_beats", 32'(beats), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sb_q.push_back(exp_t'{16'd256, 1'b0, 16'd2});
        beat(fill(4'd1), fill(4'd1), 1'b1, 1'b1, 1'b0);
        beat(fill(4'd1), fill(4'd1), 1'b1, 1'b0, 1'b1);
        idle();
        drain();
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
